// File: rtl/jtag_spi_xfer_engine.sv
// Bridges a USER DR scan from a BSCAN primitive into one framed SPI flash transaction.
// Host frame on tdi, LSB first: start bit, LEN_W-bit payload length N, then N payload bits.
module jtag_spi_xfer_engine #(
    parameter int   LEN_W     = 16,
    parameter logic START_VAL = 1'b1
) (
    input  logic drck,
    input  logic rst,
    input  logic sel,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic tdi,
    output logic tdo,
    output logic csn,
    output logic sck,
    output logic sdi_dq0,
    input  logic sdo_dq1,
    output logic wpn_dq2,
    output logic hldn_dq3,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t           state, state_next;
    logic             csn_next;
    logic             sck_en, sck_en_next;
    logic             sdi_next;
    logic             tdo_next;
    logic [LEN_W-1:0] len, len_next;
    logic [LEN_W-1:0] cnt, cnt_next;
    logic [LEN_W-1:0] len_full;
    logic             step;

    assign step = sel & shift;

    // Length value including the bit arriving on this step; len is cleared on entry to LEN.
    assign len_full = len | (LEN_W'(tdi) << cnt);

    // sck_en only moves on rising drck, while drck is high, so the gated clock cannot glitch.
    assign sck      = sck_en & ~drck;
    assign wpn_dq2  = 1'b1;
    assign hldn_dq3 = 1'b1;
    assign busy     = (state == LEN) || (state == DATA);

    always_ff @(posedge drck or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            csn     <= 1'b1;
            sck_en  <= 1'b0;
            sdi_dq0 <= 1'b0;
            tdo     <= 1'b0;
            len     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            csn     <= csn_next;
            sck_en  <= sck_en_next;
            sdi_dq0 <= sdi_next;
            tdo     <= tdo_next;
            len     <= len_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        csn_next    = csn;
        sck_en_next = sck_en;
        sdi_next    = sdi_dq0;
        tdo_next    = tdi;
        len_next    = len;
        cnt_next    = cnt;

        if (sel && update) begin
            state_next  = IDLE;
            csn_next    = 1'b1;
            sck_en_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && capture) begin
                        state_next = HUNT;
                    end
                end
                HUNT: begin
                    if (step && (tdi == START_VAL)) begin
                        state_next = LEN;
                        cnt_next   = '0;
                        len_next   = '0;
                    end
                end
                LEN: begin
                    if (step) begin
                        len_next = len_full;
                        cnt_next = cnt + LEN_W'(1);
                        if (cnt == LEN_W'(LEN_W - 1)) begin
                            if (len_full == '0) begin
                                state_next = DONE;
                            end else begin
                                state_next = DATA;
                                csn_next   = 1'b0;
                                cnt_next   = len_full;
                            end
                        end
                    end
                end
                DATA: begin
                    // The reply bit lags one step: MISO is taken at the edge ending the previous pulse.
                    tdo_next    = tdo;
                    sck_en_next = 1'b0;
                    if (step) begin
                        sdi_next    = tdi;
                        sck_en_next = 1'b1;
                        tdo_next    = sdo_dq1;
                        cnt_next    = cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    sck_en_next = 1'b0;
                    csn_next    = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_spi_xfer_engine.sv
// Randomised bench for jtag_spi_xfer_engine: host frames are built bit by bit and the flash side
// is a small MISO/MOSI model; expectations follow from the frame contents and pause placement.
module tb_jtag_spi_xfer_engine;

    localparam int LEN_W = 16;

    logic drck, rst, sel, capture, shift, update, tdi;
    logic tdo, csn, sck, sdi_dq0, sdo_dq1, wpn_dq2, hldn_dq3, busy;

    int test_count    = 0;
    int fail_count    = 0;
    int pulse_count   = 0;
    int csn_viol      = 0;
    int flash_idx     = 0;
    int rep_base      = 0;
    int csn_low_count = 0;

    logic rep_mem [0:65535];
    logic rx_mem  [0:65535];

    jtag_spi_xfer_engine #(
        .LEN_W     (LEN_W),
        .START_VAL (1'b1)
    ) dut (
        .drck     (drck),
        .rst      (rst),
        .sel      (sel),
        .capture  (capture),
        .shift    (shift),
        .update   (update),
        .tdi      (tdi),
        .tdo      (tdo),
        .csn      (csn),
        .sck      (sck),
        .sdi_dq0  (sdi_dq0),
        .sdo_dq1  (sdo_dq1),
        .wpn_dq2  (wpn_dq2),
        .hldn_dq3 (hldn_dq3),
        .busy     (busy)
    );

    initial drck = 1'b0;
    always #5 drck = ~drck;

    // Flash model: latches MOSI on rising sck, advances its reply on falling sck.
    always @(posedge sck) begin
        rx_mem[pulse_count % 65536] = sdi_dq0;
        pulse_count = pulse_count + 1;
        if (csn !== 1'b0) csn_viol = csn_viol + 1;
    end

    always @(negedge sck) flash_idx <= flash_idx + 1;

    assign sdo_dq1 = rep_mem[(flash_idx - rep_base) & 32'hFFFF];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One drck period; inputs settle just after a falling edge, outputs are read 1ns after the next.
    task automatic cycle(input logic sh, input logic d, input logic cap, input logic upd);
        shift   = sh;
        tdi     = d;
        capture = cap;
        update  = upd;
        @(negedge drck);
        #1;
        if (csn === 1'b0) csn_low_count++;
    endtask

    // stop_mode: 0 full frame, 1 update abort after stop_at bits, 2 reset pulse after stop_at bits.
    task automatic apply_stimulus(input string tag, input int lead, input int n,
                                  input logic [31:0] pay, input logic [31:0] rep,
                                  input int pause_at, input int pause_len,
                                  input int stop_at, input int stop_mode);
        logic [LEN_W-1:0] nn;
        logic [31:0]      tdo_got, tdo_exp, rx_got, mask;
        logic             paused, xb;
        int               p0, v0, sent, pauses, pp, pause_pulses;

        nn   = LEN_W'(n);
        sent = (stop_mode != 0) ? stop_at : n;
        mask = (sent >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sent) - 32'd1);
        for (int i = 0; i < 32; i++) rep_mem[i] = rep[i];
        rep_base      = flash_idx;
        p0            = pulse_count;
        v0            = csn_viol;
        csn_low_count = 0;
        pauses        = 0;
        pause_pulses  = 0;
        paused        = 1'b0;
        tdo_got       = '0;
        tdo_exp       = '0;
        rx_got        = '0;

        sel = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (lead) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_output({tag, " hunt_not_busy"}, 32'(busy), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_output({tag, " len_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < LEN_W; i++) cycle(1'b1, nn[i], 1'b0, 1'b0);

        for (int k = 0; k < sent; k++) begin
            if (k < 32) begin
                tdo_exp[k] = rep[(k == 0) ? 0 : (paused ? k : k - 1)];
                xb         = pay[k];
            end else begin
                xb = 1'($urandom_range(0, 1));
            end
            cycle(1'b1, xb, 1'b0, 1'b0);
            if (k < 32) tdo_got[k] = tdo;
            paused = 1'b0;
            if (k == pause_at && pause_len > 0) begin
                pp = pulse_count;
                repeat (pause_len) begin
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                    pauses++;
                end
                pause_pulses = pulse_count - pp;
                paused       = 1'b1;
            end
        end

        if (stop_mode == 1) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check_output({tag, " abort_csn"}, 32'(csn), 32'd1);
            check_output({tag, " abort_idle"}, 32'(busy), 32'd0);
        end else if (stop_mode == 2) begin
            rst = 1'b1;
            #1;
            check_output({tag, " rst_csn"}, 32'(csn), 32'd1);
            check_output({tag, " rst_sck"}, 32'(sck), 32'd0);
            check_output({tag, " rst_busy"}, 32'(busy), 32'd0);
            @(negedge drck);
            #1;
            rst = 1'b0;
        end else begin
            xb = 1'($urandom_range(0, 1));
            cycle(1'b1, xb, 1'b0, 1'b0);
            check_output({tag, " bypass_tdo"}, 32'(tdo), 32'(xb));
            repeat (2) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            check_output({tag, " done_not_busy"}, 32'(busy), 32'd0);
            check_output({tag, " done_csn"}, 32'(csn), 32'd1);
            check_output({tag, " csn_low_cycles"}, 32'(csn_low_count),
                         (n == 0) ? 32'd0 : 32'(n + pauses + 1));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end

        check_output({tag, " sck_pulses"}, 32'(pulse_count - p0), 32'(sent));
        check_output({tag, " sck_while_csn_high"}, 32'(csn_viol - v0), 32'd0);
        if (pause_at >= 0 && pause_at < sent && pause_len > 0)
            check_output({tag, " pause_pulses"}, 32'(pause_pulses), 32'd0);
        if (sent > 0) begin
            for (int i = 0; i < 32 && i < sent; i++) rx_got[i] = rx_mem[(p0 + i) % 65536];
            check_output({tag, " mosi_bits"}, rx_got & mask, pay & mask);
            check_output({tag, " tdo_reply"}, tdo_got & mask, tdo_exp & mask);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int n, lead, pat, plen, mode;
        rst     = 1'b1;
        sel     = 1'b0;
        capture = 1'b0;
        shift   = 1'b0;
        update  = 1'b0;
        tdi     = 1'b0;
        for (int i = 0; i < 65536; i++) rep_mem[i] = 1'b0;
        repeat (2) @(negedge drck);
        #1;
        check_output("reset csn", 32'(csn), 32'd1);
        check_output("reset sck", 32'(sck), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset tdo", 32'(tdo), 32'd0);
        check_output("reset sdi", 32'(sdi_dq0), 32'd0);
        check_output("const wpn_hldn", {30'd0, wpn_dq2, hldn_dq3}, 32'd3);
        rst = 1'b0;

        apply_stimulus("len8", 0, 8, 32'h9F, 32'hEF, -1, 0, 0, 0);
        apply_stimulus("zero_len", 5, 0, 32'h0, 32'h0, -1, 0, 0, 0);
        apply_stimulus("pause16", 0, 16, $urandom, $urandom, 7, 3, 0, 0);
        apply_stimulus("abort", 0, 32, $urandom, $urandom, -1, 0, 4, 1);

        // Without a capture, IDLE must ignore a start bit.
        sel = 1'b1;
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_output("idle_ignores_shift", 32'(busy), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        apply_stimulus("rst_mid", 2, 20, $urandom, $urandom, -1, 0, 6, 2);
        apply_stimulus("after_rst", 1, 12, $urandom, $urandom, -1, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            n    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 32);
            lead = $urandom_range(0, 6);
            pat  = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
            plen = $urandom_range(1, 4);
            mode = (n >= 2 && $urandom_range(0, 7) == 0) ? 1 : 0;
            apply_stimulus($sformatf("rand%0d", t), lead, n, $urandom, $urandom, pat, plen,
                           (mode == 1) ? $urandom_range(1, n - 1) : 0, mode);
        end

        apply_stimulus("stress", 0, 65535, $urandom, $urandom, -1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
